// File: rtl/antilog_conv.sv
// Iterative Mitchell antilogarithm: turns a 13-bit log-domain word {k, f} back into
// the linear magnitude 2^k * (1 + f/512), truncated, shifting one bit per clock.
module antilog_conv #(
  parameter int W_LOG  = 13,
  parameter int W_FRAC = 9,
  parameter int W_OUT  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W_LOG-1:0] in_log,
  input  logic             in_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W_OUT-1:0] out_lin,
  output logic [1:0]       dbg_state
);

  localparam int W_K   = W_LOG - W_FRAC;
  localparam int W_ACC = W_FRAC + 1 + W_OUT - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q;
  logic [W_ACC-1:0]   acc_q;
  logic [W_K-1:0]     cnt_q;

  logic [W_K-1:0]     in_k;
  logic [W_FRAC-1:0]  in_f;

  assign in_k = in_log[W_LOG-1:W_FRAC];
  assign in_f = in_log[W_FRAC-1:0];

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high. in_ready only in IDLE (and never during reset); out_valid only in DONE,
  // with out_lin held stable until out_ready is seen.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign out_lin   = acc_q[W_ACC-1:W_FRAC];
  assign dbg_state = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (in_zero) begin
              acc_q   <= '0;
              state_q <= DONE;
            end else begin
              // Implicit leading one of the mantissa sits just above the fraction.
              acc_q <= {{(W_OUT-1){1'b0}}, 1'b1, in_f};
              if (in_k == '0) begin
                state_q <= DONE;
              end else begin
                cnt_q   <= in_k;
                state_q <= SHIFT;
              end
            end
          end
        end
        SHIFT: begin
          acc_q <= acc_q << 1;
          cnt_q <= cnt_q - W_K'(1);
          if (cnt_q == W_K'(1)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_antilog_conv.sv
// Bench for antilog_conv: directed scenarios plus random traffic, with a queue-based
// scoreboard checking result value, latency and output stability.
module tb_antilog_conv;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] in_log;
  logic        in_zero;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_lin;
  logic [1:0]  dbg_state;

  logic        ready_fixed;
  logic        rdy_rand;
  logic        rand_bit;

  int          checks;
  int          errors;
  int          cyc;
  logic [15:0] exp_q[$];
  int          cyc_q[$];
  bit          busy;
  logic [15:0] cur_v;
  int          cur_c;

  antilog_conv dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_log    (in_log),
    .in_zero   (in_zero),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_lin   (out_lin),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1 rand_bit = 1'($urandom_range(0, 1));
  end

  assign out_ready = rdy_rand ? rand_bit : ready_fixed;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model: 2^k * (1 + f/512), truncated
  function automatic logic [15:0] model(input int k, input int f, input bit z);
    longint v;
    if (z) return 16'd0;
    v = (longint'(512 + f) * (longint'(1) << k)) / 512;
    return 16'(v);
  endfunction

  // driver tasks: inputs change 1 time unit after a rising edge
  task automatic send(input int k, input int f, input bit z);
    int budget;
    budget = 0;
    forever begin
      @(posedge clk); #1;
      if (in_ready) break;
      budget++;
      if (budget > 200) begin
        check("send_timeout", 32'd1, 32'd0);
        return;
      end
    end
    in_valid = 1'b1;
    in_log   = {4'(k), 9'(f)};
    in_zero  = z;
    exp_q.push_back(model(k, f, z));
    cyc_q.push_back(cyc + 1 + (z ? 0 : k));
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_log   = 13'($urandom);
    in_zero  = 1'b0;
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 || busy || !in_ready) begin
      @(posedge clk); #1;
      budget++;
      if (budget > 300) begin
        check("drain_timeout", 32'd1, 32'd0);
        return;
      end
    end
  endtask

  // scoreboard monitor: samples on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      busy = 1'b0;
    end else if (out_valid) begin
      if (!busy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 32'(out_lin), 32'hFFFF_FFFF);
        end else begin
          cur_v = exp_q.pop_front();
          cur_c = cyc_q.pop_front();
          busy  = 1'b1;
          check("out_latency", 32'(cyc), 32'(cur_c));
        end
      end
      if (busy) check("out_lin", 32'(out_lin), 32'(cur_v));
      check("in_ready_in_done", 32'(in_ready), 32'd0);
      if (out_ready) busy = 1'b0;
    end
  end

  initial begin
    int a;
    int budget;
    checks = 0; errors = 0; cyc = 0; busy = 1'b0;
    rst = 1'b1; in_valid = 1'b0; in_log = '0; in_zero = 1'b0;
    ready_fixed = 1'b1; rdy_rand = 1'b0; rand_bit = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_lin", 32'(out_lin), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1 check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // k = 0: result 1, in_ready back the cycle after the output handshake
    send(0, 0, 0);
    @(posedge clk); #1;
    check("k0_in_ready_back", 32'(in_ready), 32'd1);
    wait_idle();

    // k = 3: in_ready low during the shift cycles
    send(3, 256, 0);
    for (int i = 0; i < 3; i++) begin
      check("k3_in_ready_low", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    wait_idle();

    send(15, 511, 0);
    wait_idle();
    send(10, 1, 0);
    wait_idle();
    send(15, 511, 1);
    wait_idle();

    // backpressure: result held, extra input ignored
    ready_fixed = 1'b0;
    send(5, 128, 0);
    budget = 0;
    while (!out_valid && budget < 40) begin
      @(posedge clk); #1;
      budget++;
    end
    check("bp_valid_seen", 32'(out_valid), 32'd1);
    for (int i = 0; i < 6; i++) begin
      in_valid = (i == 2);
      in_log   = {4'd3, 9'd7};
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    ready_fixed = 1'b1;
    wait_idle();

    // reset during the 5th shift cycle aborts the operation
    send(12, 0, 0);
    a = cyc;
    repeat (4) begin @(posedge clk); #1; end
    check("abort_in_shift", 32'(cyc - a + 1), 32'd5);
    rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_out_lin", 32'(out_lin), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    cyc_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("abort_idle_state", 32'(dbg_state), 32'd0);
    check("abort_in_ready_back", 32'(in_ready), 32'd1);
    send(2, 0, 0);
    wait_idle();

    // random traffic with random consumer backpressure
    rdy_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send($urandom_range(0, 15), $urandom_range(0, 511), ($urandom_range(0, 7) == 0));
    end
    wait_idle();
    rdy_rand = 1'b0;
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
